// File: rtl/byte_fetch_unit.sv
// Y86-64 fetch engine: walks byte-wide instruction memory one byte per cycle
// and assembles icode/ifun/rA/rB/valC/valP for decode.
module byte_fetch_unit #(
  parameter int MEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] pcIn,
  output logic [63:0] memAddr,
  input  logic [7:0]  memByte,
  output logic        busy,
  output logic        valid,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instrValid,
  output logic        imemError
);

  typedef enum logic [2:0] {
    IDLE, OPC, REG, CONST, DONE
  } state_t;

  state_t      state;
  logic [63:0] base;
  logic [3:0]  offset;
  logic [2:0]  cidx;
  logic [3:0]  len;
  logic        has_const;

  logic [3:0]  op;
  logic [3:0]  op_len;
  logic        op_reg;
  logic        op_const;
  logic        addr_bad;

  assign memAddr  = base + 64'(offset);
  assign addr_bad = memAddr >= 64'(MEM_DEPTH);
  assign op       = memByte[7:4];

  always_comb begin
    op_len   = 4'd1;
    op_reg   = 1'b0;
    op_const = 1'b0;
    unique case (1'b1)
      (op == 4'h2) || (op == 4'h6) ||
      (op == 4'hA) || (op == 4'hB): begin
        op_len = 4'd2;
        op_reg = 1'b1;
      end
      (op == 4'h7) || (op == 4'h8): begin
        op_len   = 4'd9;
        op_const = 1'b1;
      end
      (op == 4'h3) || (op == 4'h4) ||
      (op == 4'h5): begin
        op_len   = 4'd10;
        op_reg   = 1'b1;
        op_const = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base       <= '0;
      offset     <= '0;
      cidx       <= '0;
      len        <= '0;
      has_const  <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      icode      <= '0;
      ifun       <= '0;
      rA         <= 4'hF;
      rB         <= 4'hF;
      valC       <= '0;
      valP       <= '0;
      instrValid <= 1'b0;
      imemError  <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= OPC;
            base       <= pcIn;
            offset     <= '0;
            cidx       <= '0;
            busy       <= 1'b1;
            icode      <= '0;
            ifun       <= '0;
            rA         <= 4'hF;
            rB         <= 4'hF;
            valC       <= '0;
            instrValid <= 1'b0;
            imemError  <= 1'b0;
          end
        end
        OPC: begin
          if (addr_bad) begin
            state     <= DONE;
            busy      <= 1'b0;
            valid     <= 1'b1;
            valP      <= base;
            imemError <= 1'b1;
            offset    <= '0;
          end else begin
            icode      <= memByte[7:4];
            ifun       <= memByte[3:0];
            instrValid <= memByte[7:4] <= 4'hB;
            len        <= op_len;
            has_const  <= op_const;
            offset     <= offset + 4'd1;
            if (op_reg) begin
              state <= REG;
            end else if (op_const) begin
              state <= CONST;
            end else begin
              state  <= DONE;
              busy   <= 1'b0;
              valid  <= 1'b1;
              valP   <= base + 64'(op_len);
              offset <= '0;
            end
          end
        end
        REG: begin
          if (addr_bad) begin
            state     <= DONE;
            busy      <= 1'b0;
            valid     <= 1'b1;
            valP      <= base;
            imemError <= 1'b1;
            offset    <= '0;
          end else begin
            rA     <= memByte[7:4];
            rB     <= memByte[3:0];
            offset <= offset + 4'd1;
            if (has_const) begin
              state <= CONST;
            end else begin
              state  <= DONE;
              busy   <= 1'b0;
              valid  <= 1'b1;
              valP   <= base + 64'(len);
              offset <= '0;
            end
          end
        end
        CONST: begin
          if (addr_bad) begin
            state     <= DONE;
            busy      <= 1'b0;
            valid     <= 1'b1;
            valP      <= base;
            imemError <= 1'b1;
            offset    <= '0;
          end else begin
            // little-endian: constant byte k lands in valC[8k+7:8k]
            valC[{cidx, 3'b000} +: 8] <= memByte;
            offset <= offset + 4'd1;
            cidx   <= cidx + 3'd1;
            if (cidx == 3'd7) begin
              state  <= DONE;
              busy   <= 1'b0;
              valid  <= 1'b1;
              valP   <= base + 64'(len);
              offset <= '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_fetch_unit.sv
// Randomized bench for byte_fetch_unit with an instruction-level
// reference model and a per-cycle compare process.
module tb_byte_fetch_unit;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        iv;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] pcIn;
  logic [63:0] memAddr;
  logic [7:0]  memByte;
  logic        busy;
  logic        valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instrValid;
  logic        imemError;

  logic [7:0]  mem [128];
  int          total;
  int          bad;
  int          cyc;
  int          c0;
  int          exp_vcyc;
  bit          active;
  logic [63:0] cur_pc;
  exp_t        cur;

  byte_fetch_unit #(.MEM_DEPTH(128)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pcIn(pcIn),
    .memAddr(memAddr),
    .memByte(memByte),
    .busy(busy),
    .valid(valid),
    .icode(icode),
    .ifun(ifun),
    .rA(rA),
    .rB(rB),
    .valC(valC),
    .valP(valP),
    .instrValid(instrValid),
    .imemError(imemError)
  );

  assign memByte = (memAddr < 64'd128) ? mem[memAddr[6:0]] : 8'hEE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Instruction-level model: length table, then walk the bytes in order.
  function automatic exp_t model(input logic [63:0] pc);
    exp_t        e;
    int          n;
    bit          hasreg;
    logic [7:0]  b;
    logic [63:0] a;
    e.icode = 0; e.ifun = 0; e.ra = 4'hF; e.rb = 4'hF;
    e.valc = 0; e.valp = pc; e.iv = 0; e.err = 0; e.lat = 0;
    if (pc >= 64'd128) begin
      e.err = 1; e.lat = 2;
      return e;
    end
    b = mem[pc[6:0]];
    e.icode = b[7:4];
    e.ifun  = b[3:0];
    e.iv    = b[7:4] <= 4'hB;
    case (b[7:4])
      4'h2, 4'h6, 4'hA, 4'hB: n = 2;
      4'h7, 4'h8:             n = 9;
      4'h3, 4'h4, 4'h5:       n = 10;
      default:                n = 1;
    endcase
    hasreg = (n == 2) || (n == 10);
    for (int i = 1; i < n; i++) begin
      a = pc + 64'(i);
      if (a >= 64'd128) begin
        e.err = 1; e.lat = i + 2;
        return e;
      end
      b = mem[a[6:0]];
      if (hasreg && i == 1) begin
        e.ra = b[7:4]; e.rb = b[3:0];
      end else begin
        e.valc[8*(i-1-int'(hasreg)) +: 8] = b;
      end
    end
    e.valp = pc + 64'(n);
    e.lat  = n + 1;
    return e;
  endfunction

  always @(posedge clk) begin
    #3;
    if (active) begin
      chk("valid", valid, cyc == exp_vcyc);
      chk("busy", busy, cyc > c0 && cyc < exp_vcyc);
      if (cyc >= exp_vcyc) begin
        chk("icode", icode, cur.icode);
        chk("ifun", ifun, cur.ifun);
        chk("rA", rA, cur.ra);
        chk("rB", rB, cur.rb);
        chk("valC", valC, cur.valc);
        chk("valP", valP, cur.valp);
        chk("instrValid", instrValid, cur.iv);
        chk("imemError", imemError, cur.err);
      end
      if (cyc > exp_vcyc) chk("memAddr_idle", memAddr, cur_pc);
    end
  end

  task automatic fetch(input logic [63:0] pc, input int gap, input bit noise);
    start = 1'b0;
    repeat (gap) @(negedge clk);
    cur      = model(pc);
    cur_pc   = pc;
    c0       = cyc;
    exp_vcyc = cyc + cur.lat;
    active   = 1'b1;
    start    = 1'b1;
    pcIn     = pc;
    @(negedge clk);
    while (cyc <= exp_vcyc) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pcIn  = {$urandom, $urandom};
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_icode"}, icode, 0);
    chk({tag, "_ifun"}, ifun, 0);
    chk({tag, "_rA"}, rA, 4'hF);
    chk({tag, "_rB"}, rB, 4'hF);
    chk({tag, "_valC"}, valC, 0);
    chk({tag, "_valP"}, valP, 0);
    chk({tag, "_iv"}, instrValid, 0);
    chk({tag, "_err"}, imemError, 0);
    chk({tag, "_memAddr"}, memAddr, 0);
  endtask

  initial begin
    exp_t        e;
    logic [63:0] pc;
    logic [7:0]  b10 [10];
    total = 0; bad = 0; cyc = 0; c0 = 0; exp_vcyc = 0;
    active = 1'b0; cur_pc = 0;
    rst_n = 1'b0; start = 1'b0; pcIn = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 7);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: halt
    mem[0] = 8'h00;
    e = model(0);
    chk("m1_lat", e.lat, 2);
    chk("m1_valP", e.valp, 1);
    fetch(0, 0, 1'b0);

    // 2: irmovq $0x10, %rsp
    b10 = '{8'h30, 8'hF4, 8'h10, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) mem[i] = b10[i];
    e = model(0);
    chk("m2_lat", e.lat, 11);
    chk("m2_rArB", {e.ra, e.rb}, 8'hF4);
    chk("m2_valC", e.valc, 64'h10);
    chk("m2_valP", e.valp, 10);
    fetch(0, 1, 1'b1);

    // 3: jmp-class at 20
    mem[20] = 8'h73; mem[21] = 8'h2A;
    for (int i = 22; i < 29; i++) mem[i] = 8'h00;
    e = model(20);
    chk("m3_lat", e.lat, 10);
    chk("m3_valC", e.valc, 64'h2A);
    chk("m3_valP", e.valp, 29);
    chk("m3_rArB", {e.ra, e.rb}, 8'hFF);
    fetch(20, 0, 1'b1);

    // 4: invalid opcode then back-to-back register op
    mem[5] = 8'hC0; mem[6] = 8'h60; mem[7] = 8'h23;
    e = model(5);
    chk("m4a_iv", e.iv, 0);
    chk("m4a_valP", e.valp, 6);
    fetch(5, 1, 1'b0);
    e = model(6);
    chk("m4b_rArB", {e.ra, e.rb}, 8'h23);
    chk("m4b_valP", e.valp, 8);
    fetch(6, 0, 1'b0);

    // 5: runs off the end of memory
    mem[124] = 8'h30; mem[125] = 8'hF4; mem[126] = 8'h00; mem[127] = 8'h00;
    e = model(124);
    chk("m5_err", e.err, 1);
    chk("m5_valP", e.valp, 124);
    chk("m5_lat", e.lat, 6);
    chk("m5_icode", e.icode, 3);
    fetch(124, 0, 1'b1);
    fetch(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);

    // 6: reset in the constant phase
    for (int i = 0; i < 10; i++) mem[i] = b10[i];
    @(negedge clk);
    active = 1'b0;
    start = 1'b1; pcIn = 0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrst_novalid", valid, 0);
    end

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 300; t++) begin
      for (int k = 0; k < 4; k++) mem[$urandom_range(0, 127)] = 8'($urandom);
      case ($urandom_range(0, 9))
        7, 8:    pc = 64'($urandom_range(115, 127));
        9:       pc = {$urandom, $urandom} | 64'h80;
        default: pc = 64'($urandom_range(0, 127));
      endcase
      fetch(pc, $urandom_range(0, 2), 1'b1);
    end
    repeat (3) @(negedge clk);
    active = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
